// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared definitions for the adder arbiter. This package holds
//               the default parameters, the FSM state encoding and a one-hot
//               helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    // Default configuration
    localparam int c_DEF_N   = 4;
    localparam int c_DEF_W   = 4;
    localparam int c_DEF_LAT = 1;

    // Largest supported requester count and the index width that covers it
    localparam int c_MAX_N   = 8;
    localparam int c_IDX_W   = 3;

    // FSM state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // One-hot decode of a requester index. The caller truncates the result
    // to its own requester count.
    function automatic logic [c_MAX_N-1:0] onehot(input logic [c_IDX_W-1:0] idx);
        logic [c_MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. The search starts one past
//               i_ptr and wraps modulo N. The first requester found with its
//               bit set wins.
// Ports       : i_req   [N]  request vector
//               i_ptr   [IW] index of the requester granted last
//               o_idx   [IW] winning index (0 when nothing is requested)
//               o_valid      at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int N  = c_DEF_N,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_pos;

    // Scan from the farthest candidate (ptr+N, i.e. ptr itself) down to the
    // nearest one (ptr+1). The last hit written is therefore the highest
    // priority hit, so no early exit is needed.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = N; k >= 1; k--) begin
            w_pos = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_pos]) begin
                o_idx   = w_pos;
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin controller that shares one registered adder among
//               N requesters. It captures the winner's operands, pulses AddEn,
//               waits LAT cycles and then returns Sum and Overflow with a
//               one-cycle Done pulse to the granted requester.
// Ports       : Clk, Reset (async, active-high)
//               Req[N], ReqA[N*W], ReqB[N*W]   requester side, slice i at [i*W +: W]
//               Grant[N], Done[N]             one-hot, one-cycle pulses
//               Result[W], ResultOvf, Busy    response and status
//               AddA[W], AddB[W], AddEn       adder inputs (registered)
//               AddSum[W], AddOverflow        adder outputs
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N   = c_DEF_N,
    parameter int W   = c_DEF_W,
    parameter int LAT = c_DEF_LAT
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [N-1:0]   Req,
    input  logic [N*W-1:0] ReqA,
    input  logic [N*W-1:0] ReqB,
    output logic [N-1:0]   Grant,
    output logic [N-1:0]   Done,
    output logic [W-1:0]   Result,
    output logic           ResultOvf,
    output logic           Busy,
    output logic [W-1:0]   AddA,
    output logic [W-1:0]   AddB,
    output logic           AddEn,
    input  logic [W-1:0]   AddSum,
    input  logic           AddOverflow
);

    localparam int c_IW = $clog2(N);

    logic [1:0]      r_state;
    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] r_sel;
    logic [1:0]      r_cnt;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    r_done;
    logic [W-1:0]    r_add_a;
    logic [W-1:0]    r_add_b;
    logic            r_add_en;
    logic [W-1:0]    r_result;
    logic            r_result_ovf;

    logic [c_IW-1:0] w_win;
    logic            w_win_valid;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;

    rr_pick #(
        .N  (N),
        .IW (c_IW)
    ) u_rr_pick (
        .i_req   (Req),
        .i_ptr   (r_ptr),
        .o_idx   (w_win),
        .o_valid (w_win_valid)
    );

    assign w_op_a = ReqA[w_win*W +: W];
    assign w_op_b = ReqB[w_win*W +: W];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= c_IDLE;
            r_ptr        <= c_IW'(N - 1);   // requester 0 wins first after reset
            r_sel        <= '0;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_done       <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_add_en     <= 1'b0;
            r_result     <= '0;
            r_result_ovf <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_win_valid) begin
                        r_grant  <= N'(onehot(c_IDX_W'(w_win)));
                        r_add_a  <= w_op_a;
                        r_add_b  <= w_op_b;
                        r_add_en <= 1'b1;
                        r_sel    <= w_win;
                        r_state  <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_grant  <= '0;
                    r_add_en <= 1'b0;
                    r_cnt    <= 2'(LAT - 1);
                    r_ptr    <= r_sel;
                    r_state  <= c_WAIT;
                end
                c_WAIT: begin
                    // The sum is valid in the cycle where the count reaches zero
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else begin
                        r_result     <= AddSum;
                        r_result_ovf <= AddOverflow;
                        r_done       <= N'(onehot(c_IDX_W'(r_sel)));
                        r_state      <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_done  <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Grant     = r_grant;
    assign Done      = r_done;
    assign Result    = r_result;
    assign ResultOvf = r_result_ovf;
    assign Busy      = (r_state != c_IDLE);
    assign AddA      = r_add_a;
    assign AddB      = r_add_b;
    assign AddEn     = r_add_en;

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares one registered adder datapath (operands A/B, enable, Sum/Overflow) among N requesters. It accepts one operand pair at a time, pulses the adder enable, waits out the adder latency, and returns Sum and Overflow to the granted requester with a one-cycle Done pulse. It sits between the requester logic and the single adder instance, and owns every adder input.

## Interface
- N, default 4: number of requesters, 2..8.
- W, default 4: operand and result width; must match the adder.
- LAT, default 1: adder latency, in cycles from the AddEn edge to Sum valid; range 1..4.

- Clk  in  1: clock; all state updates on the rising edge.
- Reset  in  1: asynchronous, active-high reset.
- Req  in  N: per-requester request level.
- ReqA  in  N*W: flattened operand A; slice i is bits [i*W +: W].
- ReqB  in  N*W: flattened operand B, same packing as ReqA.
- Grant  out  N: one-hot, one-cycle pulse; marks that requester's operands as captured.
- Done  out  N: one-hot, one-cycle pulse; Result and ResultOvf are valid in the same cycle.
- Result  out  W: Sum returned to the requester.
- ResultOvf  out  1: the adder's Overflow flag, passed through unmodified.
- Busy  out  1: high in every state except IDLE.
- AddA, AddB  out  W: adder operands, registered.
- AddEn  out  1: adder enable, a one-cycle pulse per operation.
- AddSum  in  W: adder Sum.
- AddOverflow  in  1: adder Overflow.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, any Req bit high:
  - Select the winner by round-robin. The search starts at Ptr+1 mod N.
  - Register Grant=onehot(winner), AddA/AddB=winner's operands, AddEn=1, Sel=winner.
  - Go to ISSUE.
- IDLE, Req==0: stay in IDLE. All pulse outputs are 0.
- ISSUE, one cycle:
  - Grant and AddEn are high.
  - Next edge: clear Grant and AddEn, load Cnt=LAT-1, set Ptr=Sel, go to WAIT.
- WAIT:
  - If Cnt!=0, decrement Cnt.
  - If Cnt==0, capture Result=AddSum and ResultOvf=AddOverflow, set Done=onehot(Sel), go to RESP.
- RESP, one cycle: Done is high. Next edge: clear Done, go to IDLE.
- Result and ResultOvf hold their values until the next capture.
- Req is sampled only in IDLE.
- Requester obligations:
  - Hold Req and operands stable until Grant is seen.
  - Drop Req no later than the cycle after Grant.
  - Requests that arrive while Busy wait; they are not lost if held.
- Round-robin: the requester granted last has the lowest priority in the next arbitration.
- Arithmetic: the controller never modifies AddSum or AddOverflow. Overflow semantics belong to the adder.

## Timing
- Reset values:
  - State=IDLE.
  - Grant=0, Done=0, Busy=0, AddEn=0.
  - AddA=0, AddB=0, Result=0, ResultOvf=0, Cnt=0.
  - Ptr=N-1, so requester 0 wins first.
- Req first seen high in IDLE in cycle t:
  - Grant and AddEn high in cycle t+1.
  - Adder samples at the end of t+1.
  - Done high in cycle t+2+LAT.
  - IDLE again in cycle t+3+LAT.
- Throughput: one operation per LAT+3 cycles under back-to-back requests.
- Simultaneous requests: exactly one Grant per arbitration; the others wait in order of the rotated priority.
- Ptr wraps from N-1 to 0.
- Reset asserted mid-operation:
  - Immediate return to the reset values.
  - The in-flight result is discarded; no Done is issued for it.
  - Arbitration restarts with requester 0 first.
- Grant and Done never overlap. AddEn is never high outside ISSUE.

## Structure
- Package adder_arb_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3),
  - the default N, W and LAT,
  - a onehot helper function.
- Sub-module rr_pick: combinational round-robin picker, N-bit Req plus pointer in, winner index plus valid out.
- The top level holds the FSM, the latency counter, the operand/result registers and the flattened slicing.

## Test plan
- Single request, N=4, LAT=1, requester 1 with A=1, B=3:
  - Grant=0010 at t+1.
  - Done=0010 at t+3.
  - Result=4, ResultOvf=0.
- Simultaneous Req=0101 after reset:
  - Requester 0 is served first, then requester 2.
  - Done order is 0001 then 0100.
- All four requesting continuously for 8 operations: Grant order 0,1,2,3,0,1,2,3, with exactly LAT+3 cycles between Grants.
- Requester 3 with A=9, B=8 against an adder model whose Overflow is the unsigned carry: Result=1, ResultOvf=1.
- LAT=3, single request: Done at t+5, Busy high from t+1 through t+5.
- Reset pulsed during WAIT:
  - Done is never asserted for that operation.
  - All outputs are 0 during reset.
  - The next Req=1000 receives Grant=1000 at t+1.
